mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
Parametrised iterative multiply/divide unit with HI/LO result registers, added so the CPU can run MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- Sits beside the ALU in the execute path and is started by decoder/ALU-control signals.
- The CPU stalls PC/IF on busy_o and reads results from hi_o/lo_o.
- Radix-2 shift-add / restoring-divide core: one iteration per clock, WIDTH iterations per operation.

Parameters:
WIDTH, 32, operand and HI/LO width; must be even and ≥4.
CNT_W, $clog2(WIDTH), width of the iteration counter.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  reset, asynchronous, active-high.
start_i  input  1  launch operation op_i on src1_i/src2_i; sampled only in IDLE.
op_i  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
src1_i  input  WIDTH  rs operand (multiplicand/dividend); also MTHI/MTLO data.
src2_i  input  WIDTH  rt operand (multiplier/divisor).
hi_we_i  input  1  MTHI: write src1_i to HI.
lo_we_i  input  1  MTLO: write src1_i to LO.
abort_i  input  1  flush: cancel in-flight operation.
busy_o  output  1  high while state ≠ IDLE (combinational from state).
done_o  output  1  one-cycle registered pulse; HI/LO valid from the same cycle.
div_zero_o  output  1  registered; set with done_o when a divide had src2_i = 0; cleared at the next accepted start.
hi_o  output  WIDTH  HI register (product upper half / remainder).
lo_o  output  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset (async, any state): state = IDLE, count = 0, hi_o = lo_o = 0, done_o = 0, div_zero_o = 0. Reset mid-operation discards it with no done.
- States: IDLE, CALC, FIX.
  - IDLE + start_i: latch the operand magnitudes. Signed ops convert negative operands to two's-complement magnitude and record the result/remainder signs. Set count = WIDTH-1 and go to CALC.
  - Exception: a divide with src2_i = 0 goes straight to FIX with a dz flag set.
- CALC: one iteration per edge.
  - Multiply: when multiplier LSB = 1, add the multiplicand to the upper accumulator (carry kept), then shift {acc, mplr} right by 1.
  - Divide: shift {rem, quot} left by 1, trial-subtract the divisor, and set quot LSB on no borrow.
  - When count = 0, go to FIX; otherwise decrement count.
- FIX: one edge. Apply sign fixup, write hi_o/lo_o, pulse done_o, go to IDLE.
  - MULT: negate the 2·WIDTH product if the signs differ.
  - DIV: quotient truncates toward zero; the remainder takes the dividend's sign.
  - dz: HI = src1 as latched, LO = all ones, div_zero_o = 1.
- Latency:
  - Start accepted at edge E0; iterations on E1..E_WIDTH; FIX on E_WIDTH+1.
  - done_o is high in the cycle after E_WIDTH+1: 34 cycles after start for WIDTH = 32.
  - busy_o is high for WIDTH+1 cycles.
  - Divide-by-zero: done_o follows 2 edges after start, busy_o high for 1 cycle.
- start_i while busy: ignored (CPU must stall).
- start_i in the done_o cycle: accepted, because state is already IDLE.
- Overflow: DIV of most-negative by -1 gives LO = most-negative, HI = 0. This falls out of magnitude arithmetic and needs no special casing.
- MTHI/MTLO:
  - Only in IDLE: write src1_i on the next edge. Ignored while busy.
  - start_i and hi_we_i/lo_we_i in the same IDLE cycle: start wins and the write is dropped.
  - hi_we_i and lo_we_i together: both written.
- abort_i: in CALC/FIX, return to IDLE on the next edge. HI/LO and div_zero_o are unchanged and done_o stays 0. abort_i has priority over FIX completion. In IDLE it is a no-op (start_i in the same cycle is ignored).
- done_o deasserts the cycle after its pulse regardless of inputs.

Decomposition:
- Shared package (mdu_pkg): op encodings MDU_MULTU/MULT/DIVU/DIV, state enum {IDLE, CALC, FIX}, and a function for two's-complement magnitude.
- One natural sub-module: mdu_step, a purely combinational single iteration (mode, acc, lo_part, operand → next acc, next lo_part). Reusable when unrolling to 2 iterations/cycle later.
- The FSM, counter and HI/LO registers stay in mul_div_unit.

Test Plan:
1. MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001; done_o exactly 34 cycles after start; busy_o high 33 cycles.
2. MULT -3 × 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. DIV -7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 100 / 7 → LO = 14, HI = 2.
3. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0, div_zero_o = 0.
4. DIVU 0x1234 / 0 → done_o 2 edges after start, div_zero_o = 1, HI = 0x1234, LO = 0xFFFFFFFF. A following valid start clears div_zero_o.
5. MTHI 0xA5A5A5A5 in IDLE → hi_o updates next edge. Repeat while busy → hi_o unchanged. A back-to-back start in the done_o cycle is accepted.
6. Start MULT, then abort_i at cycle 10 → IDLE next edge, no done_o, HI/LO retain prior values. Separately, assert rst_i asynchronously mid-CALC → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM state codes and a two's-complement magnitude helper.
package mdu_pkg;

    localparam logic [1:0] MDU_MULTU = 2'b00;
    localparam logic [1:0] MDU_MULT  = 2'b01;
    localparam logic [1:0] MDU_DIVU  = 2'b10;
    localparam logic [1:0] MDU_DIV   = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    // Wide enough for a 2*WIDTH product with WIDTH up to 64.
    localparam int MDU_MAX_W = 128;

    function automatic logic [MDU_MAX_W-1:0] mdu_mag(
        input logic [MDU_MAX_W-1:0] v,
        input logic                 neg
    );
        return neg ? (~v + MDU_MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// Purely combinational so it can be chained for multi-step unrolling.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH-1:0] diff;
    logic             no_borrow;

    always_comb begin
        sum       = {1'b0, acc_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
        shl       = {acc_i, lo_i[WIDTH-1]};
        no_borrow = shl >= {1'b0, opnd_i};
        // Remainder stays below the divisor, so a WIDTH-bit difference suffices.
        diff      = shl[WIDTH-1:0] - opnd_i;
        if (div_i) begin
            acc_o = no_borrow ? diff : shl[WIDTH-1:0];
            lo_o  = {lo_i[WIDTH-2:0], no_borrow};
        end else begin
            acc_o = sum[WIDTH:1];
            lo_o  = {sum[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO.
// One iteration per clock; sign fixup in a final FIX cycle.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             hi_we_i,
    input  logic             lo_we_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] wrk_q, wrk_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             div_q, div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dz_out_q, dz_out_d;

    logic [WIDTH-1:0]   step_acc;
    logic [WIDTH-1:0]   step_lo;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    mdu_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .div_i (div_q),
        .acc_i (acc_q),
        .lo_i  (wrk_q),
        .opnd_i(opnd_q),
        .acc_o (step_acc),
        .lo_o  (step_lo)
    );

    assign neg_a = op_i[0] & src1_i[WIDTH-1];
    assign neg_b = op_i[0] & src2_i[WIDTH-1];
    assign mag_a = WIDTH'(mdu_mag(MDU_MAX_W'(src1_i), neg_a));
    assign mag_b = WIDTH'(mdu_mag(MDU_MAX_W'(src2_i), neg_b));

    assign prod = (2*WIDTH)'(mdu_mag(MDU_MAX_W'({acc_q, wrk_q}), neg_res_q));
    assign quot = WIDTH'(mdu_mag(MDU_MAX_W'(wrk_q), neg_res_q));
    assign rem  = WIDTH'(mdu_mag(MDU_MAX_W'(acc_q), neg_rem_q));

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        wrk_d     = wrk_q;
        opnd_d    = opnd_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_out_d  = dz_out_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    div_d     = op_i[1];
                    neg_res_d = neg_a ^ neg_b;
                    neg_rem_d = neg_a;
                    acc_d     = '0;
                    count_d   = CNT_W'(WIDTH - 1);
                    dz_out_d  = 1'b0;
                    dz_d      = 1'b0;
                    state_d   = ST_CALC;
                    if (op_i[1]) begin
                        wrk_d  = mag_a;
                        opnd_d = mag_b;
                    end else begin
                        wrk_d  = mag_b;
                        opnd_d = mag_a;
                    end
                    // Divide by zero skips iteration; keep raw src1 for HI.
                    if (op_i[1] && src2_i == '0) begin
                        dz_d    = 1'b1;
                        wrk_d   = src1_i;
                        state_d = ST_FIX;
                    end
                end else begin
                    if (hi_we_i) hi_d = src1_i;
                    if (lo_we_i) lo_d = src1_i;
                end
            end
            ST_CALC: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = step_acc;
                    wrk_d = step_lo;
                    if (count_q == '0) state_d = ST_FIX;
                    else count_d = count_q - CNT_W'(1);
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!abort_i) begin
                    done_d = 1'b1;
                    if (dz_q) begin
                        hi_d     = wrk_q;
                        lo_d     = '1;
                        dz_out_d = 1'b1;
                    end else if (div_q) begin
                        hi_d = rem;
                        lo_d = quot;
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            wrk_q     <= '0;
            opnd_q    <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_out_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            wrk_q     <= wrk_d;
            opnd_q    <= opnd_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dz_out_q  <= dz_out_d;
        end
    end

    assign busy_o     = state_q != ST_IDLE;
    assign done_o     = done_q;
    assign div_zero_o = dz_out_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (WIDTH = 32).
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic         hi_we;
    logic         lo_we;
    logic         abort;
    logic         busy;
    logic         done;
    logic         dz;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .op_i      (op),
        .src1_i    (s1),
        .src2_i    (s2),
        .hi_we_i   (hi_we),
        .lo_we_i   (lo_we),
        .abort_i   (abort),
        .busy_o    (busy),
        .done_o    (done),
        .div_zero_o(dz),
        .hi_o      (hi),
        .lo_o      (lo)
    );

    // edges: clock edges after the accepting edge until done_o is seen.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          output int edges, output int bcnt);
        @(negedge clk);
        op = o; s1 = a; s2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 0;
        bcnt = busy ? 1 : 0;
        while (!done && edges < 200) begin
            @(posedge clk); #1;
            edges++;
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, dz} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000", {busy, done, dz});
        end
        checks++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            failures++;
            $display("FAIL reset_hilo got=%h_%h exp=0_0", hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_multu();
        int e, b;
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e, b);
        checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            failures++;
            $display("FAIL multu_res got=%h_%h exp=fffffffe_00000001", hi, lo);
        end
        checks++;
        if (e != 33) begin
            failures++;
            $display("FAIL multu_latency got=%0d exp=33", e);
        end
        checks++;
        if (b != 33) begin
            failures++;
            $display("FAIL multu_busy got=%0d exp=33", b);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse got=%b exp=0", done);
        end
    endtask

    task automatic test_signed();
        int e, b;
        run_op(2'b01, 32'hFFFF_FFFD, 32'd5, e, b);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
            failures++;
            $display("FAIL mult_neg got=%h_%h exp=ffffffff_fffffff1", hi, lo);
        end
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, e, b);
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            failures++;
            $display("FAIL div_neg got=%h_%h exp=ffffffff_fffffffd", hi, lo);
        end
        run_op(2'b10, 32'd100, 32'd7, e, b);
        checks++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            failures++;
            $display("FAIL divu got=%h_%h exp=00000002_0000000e", hi, lo);
        end
    endtask

    task automatic test_overflow();
        int e, b;
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, e, b);
        checks++;
        if (hi !== 32'h0 || lo !== 32'h8000_0000 || dz !== 1'b0) begin
            failures++;
            $display("FAIL div_ovf got=%h_%h dz=%b exp=0_80000000 dz=0",
                     hi, lo, dz);
        end
    endtask

    task automatic test_div_zero();
        int e, b, n;
        run_op(2'b10, 32'h1234, 32'h0, e, b);
        checks++;
        if (e != 1 || b != 1) begin
            failures++;
            $display("FAIL dz_timing got=%0d/%0d exp=1/1", e, b);
        end
        checks++;
        if (dz !== 1'b1 || hi !== 32'h1234 || lo !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL dz_res got=%b %h_%h exp=1 00001234_ffffffff",
                     dz, hi, lo);
        end
        @(negedge clk);
        op = 2'b10; s1 = 32'd9; s2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (dz !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL dz_clear got=dz%b busy%b exp=dz0 busy1", dz, busy);
        end
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != 33 || hi !== 32'd0 || lo !== 32'd3) begin
            failures++;
            $display("FAIL divu_after_dz got=%0d %h_%h exp=33 0_3", n, hi, lo);
        end
    endtask

    task automatic test_mthi();
        int n;
        @(negedge clk);
        s1 = 32'h0F0F_0F0F; hi_we = 1'b1; lo_we = 1'b1;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        checks++;
        if (hi !== 32'h0F0F_0F0F || lo !== 32'h0F0F_0F0F) begin
            failures++;
            $display("FAIL mthi_mtlo got=%h_%h exp=0f0f0f0f_0f0f0f0f", hi, lo);
        end
        @(negedge clk);
        s1 = 32'hA5A5_A5A5; hi_we = 1'b1;
        @(posedge clk); #1;
        hi_we = 1'b0;
        checks++;
        if (hi !== 32'hA5A5_A5A5 || lo !== 32'h0F0F_0F0F) begin
            failures++;
            $display("FAIL mthi got=%h_%h exp=a5a5a5a5_0f0f0f0f", hi, lo);
        end
        @(negedge clk);
        op = 2'b00; s1 = 32'd6; s2 = 32'd7; start = 1'b1; hi_we = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        checks++;
        if (hi !== 32'hA5A5_A5A5 || busy !== 1'b1) begin
            failures++;
            $display("FAIL start_wins got=%h busy%b exp=a5a5a5a5 busy1",
                     hi, busy);
        end
        @(negedge clk);
        s1 = 32'h1111_1111; hi_we = 1'b1;
        @(posedge clk); #1;
        hi_we = 1'b0;
        checks++;
        if (hi !== 32'hA5A5_A5A5) begin
            failures++;
            $display("FAIL mthi_busy got=%h exp=a5a5a5a5", hi);
        end
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd42) begin
            failures++;
            $display("FAIL multu_small got=%h_%h exp=0_0000002a", hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int e1, b1, e2, b2;
        run_op(2'b00, 32'd3, 32'd4, e1, b1);
        checks++;
        if (done !== 1'b1 || lo !== 32'd12) begin
            failures++;
            $display("FAIL b2b_first got=done%b lo=%h exp=done1 lo=c", done, lo);
        end
        run_op(2'b10, 32'd50, 32'd6, e2, b2);
        checks++;
        if (e2 != 33 || hi !== 32'd2 || lo !== 32'd8) begin
            failures++;
            $display("FAIL b2b_second got=%0d %h_%h exp=33 2_8", e2, hi, lo);
        end
    endtask

    task automatic test_abort();
        int seen;
        @(negedge clk);
        op = 2'b01; s1 = 32'd7; s2 = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle got=busy%b done%b exp=0 0", busy, done);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        checks++;
        if (seen != 0 || hi !== 32'd2 || lo !== 32'd8) begin
            failures++;
            $display("FAIL abort_keep got=%0d %h_%h exp=0 2_8", seen, hi, lo);
        end
        // Abort landing on the FIX cycle of a divide-by-zero.
        @(negedge clk);
        op = 2'b10; s1 = 32'd77; s2 = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (done !== 1'b0 || dz !== 1'b0 || hi !== 32'd2 || lo !== 32'd8
            || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_fix got=done%b dz%b busy%b %h_%h exp=0 0 0 2_8",
                     done, dz, busy, hi, lo);
        end
    endtask

    task automatic test_async_reset();
        int seen;
        @(negedge clk);
        op = 2'b00; s1 = 32'hFFFF_FFFF; s2 = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || dz !== 1'b0
            || hi !== 32'h0 || lo !== 32'h0) begin
            failures++;
            $display("FAIL async_rst got=busy%b done%b dz%b %h_%h exp=0 0 0 0_0",
                     busy, done, dz, hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL rst_discard got=%0d exp=0", seen);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        op = 2'b00;
        s1 = '0;
        s2 = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        abort = 1'b0;
        test_reset();
        test_multu();
        test_signed();
        test_overflow();
        test_div_zero();
        test_mthi();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
